mem_wb_pipe: RTL and testbench
==============================

// Module: mem_wb_pipe
// PURPOSE
//  Parametrised MEM->WB pipeline stage for the multi-issue core. It carries LANES
//  independent register-write payloads (dest addr, write enable, data).
//  It uses a valid/ready handshake with a 2-entry skid buffer, so in_ready is
//  registered and backpressure does not ripple combinationally into MEM.
//  It adds a synchronous flush and canonicalises idle lanes, so that WB never
//  issues a spurious register-file write.
// PARAMETERS
//  LANES     1   number of parallel writeback lanes
//  DATA_W    32  width of each lane's write data
//  ADDR_W    5   width of each lane's destination register address
//  NOP_ADDR  0   address driven on a lane that is idle, invalid or reset
// PORTS
//  clk        in   1              clock, rising edge
//  rst        in   1              asynchronous, active-high reset
//  flush      in   1              synchronous clear of all buffered entries
//  in_valid   in   1              MEM presents a payload
//  in_ready   out  1              stage can accept; registered
//  in_wd      in   LANES*ADDR_W   per-lane destination addr; lane i = [i*ADDR_W +: ADDR_W]
//  in_wreg    in   LANES          per-lane write enable
//  in_wdata   in   LANES*DATA_W   per-lane write data
//  out_valid  out  1              WB payload valid
//  out_ready  in   1              WB consumes payload this cycle
//  wb_wd      out  LANES*ADDR_W   per-lane destination addr to WB
//  wb_wreg    out  LANES          per-lane write enable to WB
//  wb_wdata   out  LANES*DATA_W   per-lane write data to WB
//  occupancy  out  2              buffered entries: 0, 1 or 2
// BEHAVIOUR
//  - Reset (async, any time, including mid-transfer):
//    - out_valid=0, wb_wd=all NOP_ADDR, wb_wreg=0, wb_wdata=0.
//    - Skid entry is invalidated; occupancy=0.
//    - in_ready=0 while rst is high, and 1 on the first edge after release.
//  - Transfers: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
//  - Capture canonicalisation: a lane with in_wreg=0 is stored as
//    wd=NOP_ADDR, wdata=0. A lane with in_wreg=1 is stored verbatim.
//  - State machine (2 bits), advancing on the rising edge:
//    - EMPTY (occ 0):
//      - in_fire -> ONE; the main register takes the input.
//      - Otherwise stay in EMPTY.
//    - ONE (occ 1):
//      - in_fire & out_fire -> ONE; main is replaced by the input.
//      - in_fire & !out_fire -> FULL; skid takes the input and main holds.
//      - !in_fire & out_fire -> EMPTY.
//      - Otherwise hold.
//    - FULL (occ 2; in_ready=0, so no in_fire is possible):
//      - out_fire -> ONE; main <= skid, skid is invalidated.
//      - Otherwise hold.
//  - Port assignments:
//    - in_ready = (state != FULL), taken from a register.
//    - out_valid = (state != EMPTY), taken from a register.
//  - Latency:
//    - From EMPTY: 1 cycle from in_fire to out_valid.
//    - Sustained throughput is 1 payload/cycle while out_ready=1.
//  - Whenever out_valid=0, the wb_* outputs are forced to the reset/NOP values.
//    WB may therefore ignore out_valid for write gating.
//  - Payload order is strictly FIFO; payloads are never dropped or duplicated.
//  - flush=1 at an edge:
//    - Next state is EMPTY and both entries are cleared to NOP values.
//    - flush overrides any in_fire or out_fire in the same cycle; those are
//      discarded, and the producer must treat them as not accepted.
//  - Held outputs stay stable while out_valid=1 and out_ready=0.
//  - Lanes are independent. LANES=1 with out_ready tied to 1 degenerates to a
//    plain MEM/WB register with clear.
// TESTING
//  1. Reset: assert rst mid-stream with occ=2.
//     -> Outputs immediately show out_valid=0, wb_wreg=0, wb_wd=0, occ=0.
//     -> in_ready=1 one edge after release.
//  2. Streaming: LANES=2, out_ready=1, payloads (wd=3,wreg=1,data=0xA5) then (wd=7,...) each cycle.
//     -> The WB side shows them 1 cycle later, back-to-back, with in_ready held at 1.
//  3. Backpressure: hold out_ready=0 and offer 3 payloads.
//     -> The first 2 are accepted, occ=2, and in_ready=0 from the next cycle.
//     -> With out_ready=1, they drain in order and the third is then accepted.
//  4. Idle lane: lane1 wreg=0 with wd=9, wdata=0xFFFF_FFFF.
//     -> WB lane1 shows wd=NOP_ADDR, wdata=0, wreg=0; lane0 is unaffected.
//  5. Flush at occ=2 in the same cycle as in_valid=1 and out_ready=1.
//     -> Next cycle: occ=0, out_valid=0, no payload emitted or accepted.
//  6. Simultaneous fire in ONE: in_fire & out_fire for 4 cycles.
//     -> occ stays 1 and each output equals the previous cycle's input.

Source files
------------

// File: rtl/mem_wb_pipe.sv
// ---------------------------------------------------------------------------
// mem_wb_pipe
//
// MEM->WB pipeline stage for the multi-issue core. It carries LANES
// independent register-write payloads. Each payload has a destination
// address, a write enable and write data.
//
// The MEM side uses a valid/ready handshake. A two-entry buffer (a main
// register plus a skid register) lets in_ready come straight from a flop,
// so backpressure from WB never ripples combinationally back into MEM.
//
// A synchronous flush discards everything held in the stage. Idle lanes are
// canonicalised to a NOP write, so WB never sees a spurious register write.
//
// Ports
//   clk        : clock, rising edge
//   rst        : asynchronous active-high reset
//   flush      : synchronous clear of all buffered entries
//   in_valid   : MEM presents a payload
//   in_ready   : stage can accept a payload (registered)
//   in_wd      : per-lane destination address, lane i = [i*ADDR_W +: ADDR_W]
//   in_wreg    : per-lane write enable
//   in_wdata   : per-lane write data, lane i = [i*DATA_W +: DATA_W]
//   out_valid  : WB payload valid (registered)
//   out_ready  : WB consumes the payload this cycle
//   wb_wd      : per-lane destination address to WB (NOP when idle)
//   wb_wreg    : per-lane write enable to WB (0 when idle)
//   wb_wdata   : per-lane write data to WB (0 when idle)
//   occupancy  : number of buffered entries, 0..2
// ---------------------------------------------------------------------------
module mem_wb_pipe #(
  parameter int LANES    = 1,
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NOP_ADDR = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*ADDR_W-1:0] in_wd,
  input  logic [LANES-1:0]        in_wreg,
  input  logic [LANES*DATA_W-1:0] in_wdata,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*ADDR_W-1:0] wb_wd,
  output logic [LANES-1:0]        wb_wreg,
  output logic [LANES*DATA_W-1:0] wb_wdata,
  output logic [1:0]              occupancy
);

  // The state encoding equals the occupancy count, so occupancy is the state.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  localparam logic [ADDR_W-1:0]       NOP_A     = ADDR_W'(NOP_ADDR);
  localparam logic [LANES*ADDR_W-1:0] NOP_WD    = {LANES{NOP_A}};
  localparam logic [LANES-1:0]        NOP_WREG  = '0;
  localparam logic [LANES*DATA_W-1:0] NOP_WDATA = '0;

  state_e                  state_q, state_d;
  logic                    inReady_q;
  logic                    outValid_q;

  logic [LANES*ADDR_W-1:0] mainWd_q, mainWd_d;
  logic [LANES-1:0]        mainWreg_q, mainWreg_d;
  logic [LANES*DATA_W-1:0] mainWdata_q, mainWdata_d;

  logic [LANES*ADDR_W-1:0] skidWd_q, skidWd_d;
  logic [LANES-1:0]        skidWreg_q, skidWreg_d;
  logic [LANES*DATA_W-1:0] skidWdata_q, skidWdata_d;

  logic [LANES*ADDR_W-1:0] capWd;
  logic [LANES-1:0]        capWreg;
  logic [LANES*DATA_W-1:0] capWdata;

  logic                    inFire;
  logic                    outFire;

  assign inFire  = in_valid & inReady_q;
  assign outFire = outValid_q & out_ready;

  // Canonicalise the incoming payload. A lane that does not write is stored
  // as a NOP, so a stale address or data word can never leak through to WB.
  always_comb begin
    capWd    = NOP_WD;
    capWreg  = in_wreg;
    capWdata = NOP_WDATA;
    for (int i = 0; i < LANES; i++) begin
      if (in_wreg[i]) begin
        capWd[i*ADDR_W +: ADDR_W]    = in_wd[i*ADDR_W +: ADDR_W];
        capWdata[i*DATA_W +: DATA_W] = in_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  // Next-state logic. When one entry is held and both sides fire, the main
  // register is replaced directly; the skid register is used only while WB
  // stalls. Flush wins over any handshake in the same cycle.
  always_comb begin
    state_d     = state_q;
    mainWd_d    = mainWd_q;
    mainWreg_d  = mainWreg_q;
    mainWdata_d = mainWdata_q;
    skidWd_d    = skidWd_q;
    skidWreg_d  = skidWreg_q;
    skidWdata_d = skidWdata_q;

    unique case (state_q)
      EMPTY: begin
        if (inFire) begin
          state_d     = ONE;
          mainWd_d    = capWd;
          mainWreg_d  = capWreg;
          mainWdata_d = capWdata;
        end
      end
      ONE: begin
        if (inFire && outFire) begin
          mainWd_d    = capWd;
          mainWreg_d  = capWreg;
          mainWdata_d = capWdata;
        end else if (inFire) begin
          state_d     = FULL;
          skidWd_d    = capWd;
          skidWreg_d  = capWreg;
          skidWdata_d = capWdata;
        end else if (outFire) begin
          state_d     = EMPTY;
          mainWd_d    = NOP_WD;
          mainWreg_d  = NOP_WREG;
          mainWdata_d = NOP_WDATA;
        end
      end
      FULL: begin
        if (outFire) begin
          state_d     = ONE;
          mainWd_d    = skidWd_q;
          mainWreg_d  = skidWreg_q;
          mainWdata_d = skidWdata_q;
          skidWd_d    = NOP_WD;
          skidWreg_d  = NOP_WREG;
          skidWdata_d = NOP_WDATA;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase

    if (flush) begin
      state_d     = EMPTY;
      mainWd_d    = NOP_WD;
      mainWreg_d  = NOP_WREG;
      mainWdata_d = NOP_WDATA;
      skidWd_d    = NOP_WD;
      skidWreg_d  = NOP_WREG;
      skidWdata_d = NOP_WDATA;
    end
  end

  // The handshake flops are loaded from the next state, so they always agree
  // with state_q. in_ready stays low during reset and rises on the first edge
  // after reset is released.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= EMPTY;
      inReady_q   <= 1'b0;
      outValid_q  <= 1'b0;
      mainWd_q    <= NOP_WD;
      mainWreg_q  <= NOP_WREG;
      mainWdata_q <= NOP_WDATA;
      skidWd_q    <= NOP_WD;
      skidWreg_q  <= NOP_WREG;
      skidWdata_q <= NOP_WDATA;
    end else begin
      state_q     <= state_d;
      inReady_q   <= (state_d != FULL);
      outValid_q  <= (state_d != EMPTY);
      mainWd_q    <= mainWd_d;
      mainWreg_q  <= mainWreg_d;
      mainWdata_q <= mainWdata_d;
      skidWd_q    <= skidWd_d;
      skidWreg_q  <= skidWreg_d;
      skidWdata_q <= skidWdata_d;
    end
  end

  // The WB payload is gated by out_valid, so WB can use wb_wreg alone to
  // decide whether to write.
  assign in_ready  = inReady_q;
  assign out_valid = outValid_q;
  assign wb_wd     = outValid_q ? mainWd_q    : NOP_WD;
  assign wb_wreg   = outValid_q ? mainWreg_q  : NOP_WREG;
  assign wb_wdata  = outValid_q ? mainWdata_q : NOP_WDATA;
  assign occupancy = state_q;

endmodule

// File: tb/tb_mem_wb_pipe.sv
// ---------------------------------------------------------------------------
// tb_mem_wb_pipe
//
// Directed testbench for mem_wb_pipe with two lanes and NOP address 0.
// Each scenario task drives stimulus and checks the full observable state
// against hand-computed values. Packed layout of a snapshot:
//   {in_ready, occupancy, out_valid, wd1, wd0, wreg[1:0], data1, data0}
// ---------------------------------------------------------------------------
module tb_mem_wb_pipe;

  localparam int LANES  = 2;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  logic                    clk;
  logic                    rst;
  logic                    flush;
  logic                    in_valid;
  logic                    in_ready;
  logic [LANES*ADDR_W-1:0] in_wd;
  logic [LANES-1:0]        in_wreg;
  logic [LANES*DATA_W-1:0] in_wdata;
  logic                    out_valid;
  logic                    out_ready;
  logic [LANES*ADDR_W-1:0] wb_wd;
  logic [LANES-1:0]        wb_wreg;
  logic [LANES*DATA_W-1:0] wb_wdata;
  logic [1:0]              occupancy;

  int checkCount = 0;
  int passCount  = 0;

  logic [79:0] got;
  logic [79:0] want;

  mem_wb_pipe #(
    .LANES(LANES),
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .NOP_ADDR(0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .flush(flush),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_wd(in_wd),
    .in_wreg(in_wreg),
    .in_wdata(in_wdata),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .wb_wd(wb_wd),
    .wb_wreg(wb_wreg),
    .wb_wdata(wb_wdata),
    .occupancy(occupancy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Global time bound so the bench can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [79:0] snap();
    return {in_ready, occupancy, out_valid, wb_wd[9:5], wb_wd[4:0], wb_wreg,
            wb_wdata[63:32], wb_wdata[31:0]};
  endfunction

  function automatic logic [79:0] expv(input logic rdy, input logic [1:0] occ,
                                       input logic v, input logic [4:0] wd1,
                                       input logic [4:0] wd0, input logic [1:0] wreg,
                                       input logic [31:0] d1, input logic [31:0] d0);
    return {rdy, occ, v, wd1, wd0, wreg, d1, d0};
  endfunction

  // Advance to just after the next rising edge; inputs are driven and outputs
  // sampled here, well away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [4:0] wd1, input logic [4:0] wd0,
                       input logic [1:0] wreg, input logic [31:0] d1,
                       input logic [31:0] d0);
    in_valid = 1'b1;
    in_wd    = {wd1, wd0};
    in_wreg  = wreg;
    in_wdata = {d1, d0};
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_wd     = '0;
    in_wreg   = '0;
    in_wdata  = '0;
    out_ready = 1'b0;
    #12;
    checkCount++; got = snap(); want = expv(0, 0, 0, 0, 0, 0, 0, 0);
    if (got !== want) $display("[TB] FAIL reset_held: got %h want %h", got, want);
    else passCount++;
    #1 rst = 1'b0;
    tick();
    checkCount++; got = snap(); want = expv(1, 0, 0, 0, 0, 0, 0, 0);
    if (got !== want) $display("[TB] FAIL reset_release: got %h want %h", got, want);
    else passCount++;
  endtask

  task automatic test_stream();
    out_ready = 1'b1;
    drive(5'd4, 5'd3, 2'b11, 32'h11, 32'hA5);
    tick();
    checkCount++; got = snap(); want = expv(1, 1, 1, 4, 3, 2'b11, 32'h11, 32'hA5);
    if (got !== want) $display("[TB] FAIL stream_p1: got %h want %h", got, want);
    else passCount++;
    drive(5'd8, 5'd7, 2'b11, 32'h22, 32'h5A);
    tick();
    checkCount++; got = snap(); want = expv(1, 1, 1, 8, 7, 2'b11, 32'h22, 32'h5A);
    if (got !== want) $display("[TB] FAIL stream_p2: got %h want %h", got, want);
    else passCount++;
    in_valid = 1'b0;
    tick();
    checkCount++; got = snap(); want = expv(1, 0, 0, 0, 0, 0, 0, 0);
    if (got !== want) $display("[TB] FAIL stream_drain: got %h want %h", got, want);
    else passCount++;
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    drive(5'd2, 5'd1, 2'b11, 32'hA1, 32'hA0);
    tick();
    checkCount++; got = snap(); want = expv(1, 1, 1, 2, 1, 2'b11, 32'hA1, 32'hA0);
    if (got !== want) $display("[TB] FAIL bp_first: got %h want %h", got, want);
    else passCount++;
    drive(5'd4, 5'd3, 2'b11, 32'hB1, 32'hB0);
    tick();
    checkCount++; got = snap(); want = expv(0, 2, 1, 2, 1, 2'b11, 32'hA1, 32'hA0);
    if (got !== want) $display("[TB] FAIL bp_full: got %h want %h", got, want);
    else passCount++;
    drive(5'd6, 5'd5, 2'b11, 32'hC1, 32'hC0);
    tick();
    checkCount++; got = snap(); want = expv(0, 2, 1, 2, 1, 2'b11, 32'hA1, 32'hA0);
    if (got !== want) $display("[TB] FAIL bp_hold: got %h want %h", got, want);
    else passCount++;
    out_ready = 1'b1;
    tick();
    checkCount++; got = snap(); want = expv(1, 1, 1, 4, 3, 2'b11, 32'hB1, 32'hB0);
    if (got !== want) $display("[TB] FAIL bp_second: got %h want %h", got, want);
    else passCount++;
    tick();
    checkCount++; got = snap(); want = expv(1, 1, 1, 6, 5, 2'b11, 32'hC1, 32'hC0);
    if (got !== want) $display("[TB] FAIL bp_third: got %h want %h", got, want);
    else passCount++;
    in_valid = 1'b0;
    tick();
    checkCount++; got = snap(); want = expv(1, 0, 0, 0, 0, 0, 0, 0);
    if (got !== want) $display("[TB] FAIL bp_drain: got %h want %h", got, want);
    else passCount++;
  endtask

  task automatic test_idle_lane();
    out_ready = 1'b0;
    drive(5'd9, 5'd5, 2'b01, 32'hFFFF_FFFF, 32'h1234);
    tick();
    checkCount++; got = snap(); want = expv(1, 1, 1, 0, 5, 2'b01, 32'h0, 32'h1234);
    if (got !== want) $display("[TB] FAIL idle_lane: got %h want %h", got, want);
    else passCount++;
    in_valid = 1'b0;
    tick();
    checkCount++; got = snap(); want = expv(1, 1, 1, 0, 5, 2'b01, 32'h0, 32'h1234);
    if (got !== want) $display("[TB] FAIL idle_lane_stable: got %h want %h", got, want);
    else passCount++;
    out_ready = 1'b1;
    tick();
    checkCount++; got = snap(); want = expv(1, 0, 0, 0, 0, 0, 0, 0);
    if (got !== want) $display("[TB] FAIL idle_lane_drain: got %h want %h", got, want);
    else passCount++;
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    drive(5'd12, 5'd11, 2'b11, 32'hD1, 32'hD0);
    tick();
    drive(5'd14, 5'd13, 2'b11, 32'hE1, 32'hE0);
    tick();
    checkCount++; got = snap(); want = expv(0, 2, 1, 12, 11, 2'b11, 32'hD1, 32'hD0);
    if (got !== want) $display("[TB] FAIL flush_setup: got %h want %h", got, want);
    else passCount++;
    drive(5'd16, 5'd15, 2'b11, 32'hF1, 32'hF0);
    out_ready = 1'b1;
    flush     = 1'b1;
    tick();
    checkCount++; got = snap(); want = expv(1, 0, 0, 0, 0, 0, 0, 0);
    if (got !== want) $display("[TB] FAIL flush_clear: got %h want %h", got, want);
    else passCount++;
    flush    = 1'b0;
    in_valid = 1'b0;
    tick();
    checkCount++; got = snap(); want = expv(1, 0, 0, 0, 0, 0, 0, 0);
    if (got !== want) $display("[TB] FAIL flush_nothing_accepted: got %h want %h", got, want);
    else passCount++;
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      drive(5'(k + 10), 5'(k + 1), 2'b11, 32'h0BAD_0000 + 32'(k), 32'hC0DE_0000 + 32'(k));
      tick();
      checkCount++; got = snap();
      want = expv(1, 1, 1, 5'(k + 10), 5'(k + 1), 2'b11,
                  32'h0BAD_0000 + 32'(k), 32'hC0DE_0000 + 32'(k));
      if (got !== want) $display("[TB] FAIL b2b_%0d: got %h want %h", k, got, want);
      else passCount++;
    end
    in_valid = 1'b0;
    tick();
    checkCount++; got = snap(); want = expv(1, 0, 0, 0, 0, 0, 0, 0);
    if (got !== want) $display("[TB] FAIL b2b_drain: got %h want %h", got, want);
    else passCount++;
  endtask

  task automatic test_reset_midstream();
    out_ready = 1'b0;
    drive(5'd21, 5'd20, 2'b11, 32'h71, 32'h70);
    tick();
    drive(5'd23, 5'd22, 2'b11, 32'h81, 32'h80);
    tick();
    in_valid = 1'b0;
    checkCount++; got = snap(); want = expv(0, 2, 1, 21, 20, 2'b11, 32'h71, 32'h70);
    if (got !== want) $display("[TB] FAIL rst_mid_setup: got %h want %h", got, want);
    else passCount++;
    #3 rst = 1'b1;
    #1;
    checkCount++; got = snap(); want = expv(0, 0, 0, 0, 0, 0, 0, 0);
    if (got !== want) $display("[TB] FAIL rst_mid_async: got %h want %h", got, want);
    else passCount++;
    tick();
    checkCount++; got = snap(); want = expv(0, 0, 0, 0, 0, 0, 0, 0);
    if (got !== want) $display("[TB] FAIL rst_mid_held: got %h want %h", got, want);
    else passCount++;
    #3 rst = 1'b0;
    tick();
    checkCount++; got = snap(); want = expv(1, 0, 0, 0, 0, 0, 0, 0);
    if (got !== want) $display("[TB] FAIL rst_mid_release: got %h want %h", got, want);
    else passCount++;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_idle_lane();
    test_flush();
    test_back_to_back();
    test_reset_midstream();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
